packed_lane_unpacker: RTL
=========================

Name: packed_lane_unpacker

Overview:
- Sits downstream of the 32-bit packed adder/accumulator in the mixed-precision MAC path, at the receiving end of the packed-lane format.
- In mode_3 each packed result word holds two signed lanes: low lane in bits 11:0, high lane in bits 27:16. Bits 15:12 and 31:28 are guard bits that may hold carry garbage.
- The block accepts packed words over a valid/ready stream and emits sign-extended 32-bit scalars, one per lane, over a second valid/ready stream.
- In normal mode the word passes through unchanged as one scalar.

Parameters:
- LANE_W, 12, significant bits per lane, including the sign bit. Legal range 1..LANE_OFF.
- LANE_OFF, 16, bit offset of the high lane. 2*LANE_OFF must be ≤ 32.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  synchronous flush; discards held word
- in_valid_i  in  1  packed word valid
- in_ready_o  out  1  block can accept a word this cycle
- in_data_i  in  32  packed accumulator word
- in_mode3_i  in  1  1 = two-lane packed word, 0 = plain 32-bit word
- out_valid_o  out  1  scalar valid
- out_ready_i  in  1  downstream accepts scalar
- out_data_o  out  32  sign-extended scalar
- out_lane_o  out  1  0 = low lane or passthrough, 1 = high lane
- out_last_o  out  1  final scalar of the current input word

Behaviour:
- State register with states EMPTY, PASS, LO, HI. Holding registers hold_q[31:0] and mode_q.
- Reset (rst_i=1 at a clock edge):
  - state goes to EMPTY; hold_q and mode_q go to 0.
  - All outputs read 0 the next cycle: out_valid_o=0, out_data_o=0, out_lane_o=0, out_last_o=0.
  - in_ready_o=0 while rst_i is high and 1 after reset releases.
  - Reset mid-word drops the word and produces no partial output.
- clear_i:
  - Same effect as reset on state, but hold_q is unchanged.
  - Priority: rst_i > clear_i > stream activity.
  - in_ready_o=0 while clear_i=1; an input offered in that cycle is not taken.
- Output decode (combinational from state and hold_q):
  - EMPTY: out_valid_o=0, out_data_o=0.
  - PASS: out_data_o = hold_q; lane=0; last=1.
  - LO: out_data_o = sign-extend(hold_q[LANE_W-1:0]); lane=0; last=0.
  - HI: out_data_o = sign-extend(hold_q[LANE_OFF+LANE_W-1:LANE_OFF]); lane=1; last=1.
  - out_valid_o=1 in PASS, LO, HI.
  - Guard bits (LANE_W..LANE_OFF-1 and LANE_OFF+LANE_W..31) never affect the output.
- Input handshake:
  - in_ready_o = (state==EMPTY) | (out_last_o & out_ready_i), gated by !clear_i.
  - A word is captured when in_valid_i & in_ready_o: hold_q <= in_data_i, mode_q <= in_mode3_i.
  - Next state is LO if in_mode3_i=1, else PASS.
- Transitions:
  - EMPTY to LO/PASS on capture.
  - LO to HI on out_ready_i.
  - PASS/HI on out_ready_i: go to LO/PASS if a simultaneous capture occurs, else EMPTY.
  - No out_ready_i: the state holds.
- Simultaneous last-accept and new input: both happen in the same cycle with no bubble.
  - Passthrough throughput is 1 word/clock.
  - mode_3 throughput is 1 word per 2 clocks.
- Latency: a captured word's first scalar is valid the cycle after capture.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_data_o, out_lane_o and out_last_o hold constant.
- in_mode3_i is sampled only at capture. Changes at other times have no effect.

Test Plan:
- Reset, then mode_3 word 32'h0ABC_1FFD with out_ready_i=1. Required: 32'hFFFF_FFFD (lane 0, last 0), then 32'hFFFF_FABC (lane 1, last 1) on consecutive cycles; in_ready_o=0 on the LO cycle.
- Passthrough back-to-back: words 32'h8000_0001 and 32'h1234_5678, in_mode3_i=0, out_ready_i=1. Required: one scalar per cycle, equal to the inputs, with no bubble; in_ready_o stays 1.
- Backpressure: word 32'h07FF_F800 in mode_3 with out_ready_i=0 for 3 cycles. Required: out_data_o holds 32'hFFFF_F800 and in_ready_o=0. Then out_ready_i=1 gives 32'h0000_07FF.
- Guard bits: mode_3 word 32'hF123_E456. Required: 32'h0000_0456, then 32'h0000_0123 (guard nibbles ignored).
- Reset while in HI state (after LO was accepted). Required: out_valid_o=0 the next cycle, no further scalars, in_ready_o=1 after release.
- clear_i asserted in LO together with in_valid_i. Required: state goes to EMPTY, the input is not taken, and no high lane is emitted.

Source files
------------

// File: rtl/packed_lane_unpacker.sv
// Splits packed mode_3 accumulator words into two sign-extended 32-bit lane scalars.
// Plain words pass through unchanged as a single scalar.
module packed_lane_unpacker #(
  parameter int unsigned LANE_W   = 12,
  parameter int unsigned LANE_OFF = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_mode3_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_lane_o,
  output logic        out_last_o
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StPass  = 2'd1;
  localparam logic [1:0] StLo    = 2'd2;
  localparam logic [1:0] StHi    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        mode_q, mode_d;
  logic        capture;
  logic [1:0]  capture_state;

  logic [LANE_W-1:0] lo_lane;
  logic [LANE_W-1:0] hi_lane;
  logic [31:0]       lo_ext;
  logic [31:0]       hi_ext;

  // Guard bits between and above the lanes are simply never selected.
  assign lo_lane = hold_q[LANE_W-1:0];
  assign hi_lane = hold_q[LANE_OFF+LANE_W-1:LANE_OFF];
  assign lo_ext  = {{(32-LANE_W){lo_lane[LANE_W-1]}}, lo_lane};
  assign hi_ext  = {{(32-LANE_W){hi_lane[LANE_W-1]}}, hi_lane};

  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_lane_o  = 1'b0;
    out_last_o  = 1'b0;
    unique case (state_q)
      StPass: begin
        out_valid_o = 1'b1;
        out_data_o  = hold_q;
        out_last_o  = 1'b1;
      end
      StLo: begin
        out_valid_o = 1'b1;
        out_data_o  = lo_ext;
      end
      StHi: begin
        out_valid_o = 1'b1;
        out_data_o  = hi_ext;
        out_lane_o  = 1'b1;
        out_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Accepting the final scalar frees the holding register in the same cycle.
  assign in_ready_o = ~rst_i & ~clear_i &
                      ((state_q == StEmpty) | (out_last_o & out_ready_i));
  assign capture       = in_valid_i & in_ready_o;
  assign capture_state = in_mode3_i ? StLo : StPass;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    if (capture) begin
      hold_d = in_data_i;
      mode_d = in_mode3_i;
    end
    unique case (state_q)
      StEmpty: if (capture) state_d = capture_state;
      StLo:    if (out_ready_i) state_d = mode_q ? StHi : StEmpty;
      StPass, StHi: begin
        if (out_ready_i) state_d = capture ? capture_state : StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (clear_i) state_d = StEmpty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
    end
  end

endmodule
